sp_sram_arb: RTL and testbench
==============================

SP_SRAM_ARB -- requirements
Module: sp_sram_arb

Interface
REQ-001 SHALL have parameter INIT_VAL, default 8'h00: the value written to every SRAM word during the init sweep.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the posedge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports req_a / req_b, input, 1 each: access request from requester A / B.
REQ-005 SHALL have ports we_a / we_b, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports addr_a / addr_b, input, 3 each: word address 0..7.
REQ-007 SHALL have ports wdata_a / wdata_b, input, 8 each: write data.
REQ-008 SHALL have port clr, input, 1: synchronous request to re-run the init sweep.
REQ-009 SHALL have ports gnt_a / gnt_b, output, 1 each: combinational grant; the access occurs at the next posedge.
REQ-010 SHALL have ports rvalid_a / rvalid_b, output, 1 each: registered; rdata is valid for that requester.
REQ-011 SHALL have port rdata, output, 8: equal to mem_dout.
REQ-012 SHALL have port init_done, output, 1: high in RUN state.
REQ-013 SHALL have ports mem_addr (output, 3), mem_din (output, 8) and mem_wr_en (output, 1): drive the sp_sram port.
REQ-014 SHALL have port mem_dout, input, 8: sp_sram read data.

Function
REQ-015 SHALL rely on this SRAM contract: write at the posedge when mem_wr_en=1; when mem_wr_en=0, mem_dout <= mem[mem_addr] at the posedge.
REQ-016 SHALL implement FSM states INIT and RUN.
REQ-017 INIT SHALL use a 3-bit counter cnt, starting at 0: mem_wr_en=1, mem_addr=cnt, mem_din=INIT_VAL, and gnt_a=gnt_b=0.
REQ-018 INIT SHALL increment cnt each cycle and go to RUN on the cycle after the write with cnt=7 (8 cycles total); cnt wraps to 0.
REQ-019 In RUN, if exactly one of req_a/req_b is high, that requester SHALL be granted in the same cycle.
REQ-020 In RUN, if both requests are high, the requester not recorded in last_win SHALL be granted (round-robin); last_win SHALL update on every grant.
REQ-021 With no request in RUN: no grant; mem_wr_en=0; mem_addr and mem_din hold their previous values (registered mux select).
REQ-022 While a grant is active, mem_addr, mem_din and mem_wr_en SHALL equal the granted requester's addr, wdata and we.
REQ-023 Read latency SHALL be 1 cycle: a read granted in cycle N gives rvalid_x=1 in cycle N+1, with rdata = mem[addr] as of edge N.
REQ-024 A write granted in cycle N SHALL update the SRAM at edge N; a read of the same address granted in cycle N+1 SHALL return the new data.
REQ-025 Write grants SHALL NOT produce rvalid.
REQ-026 rvalid_a and rvalid_b SHALL never be high together.
REQ-027 If clr=1 in RUN: no grant that cycle; next state is INIT with cnt=0.
REQ-028 A read granted in the cycle before clr SHALL still deliver rvalid.
REQ-029 clr SHALL be ignored during INIT.
REQ-030 Back-to-back grants SHALL be supported; the throughput is 1 access per cycle.

Reset
REQ-031 While rst=0, all of the following SHALL be 0: gnt_a, gnt_b, rvalid_a, rvalid_b, init_done, mem_wr_en, mem_addr and mem_din.
REQ-032 While rst=0: state=INIT, cnt=0, last_win=B (so A wins the first conflict).
REQ-033 The sweep SHALL start on the first posedge after rst rises.
REQ-034 Reset asserted mid-sweep or mid-access SHALL abort immediately.
REQ-035 An in-flight rvalid SHALL be discarded on reset, and the sweep SHALL restart from address 0.

Verification
REQ-036 Release rst, no requests -> mem_wr_en=1 for 8 cycles with mem_addr 0..7 and mem_din=INIT_VAL; init_done rises on cycle 9; no gnt during the sweep.
REQ-037 After init, A writes 8'hA5 to address 3, then A reads address 3 -> gnt_a each cycle; rvalid_a one cycle after the read grant with rdata=8'hA5; rvalid_b=0 throughout.
REQ-038 req_a and req_b held high for 4 cycles, both reading (A addr 1, B addr 2) -> grants A,B,A,B; rvalid alternates; rdata is the respective word.
REQ-039 Only req_b high during a conflict history -> gnt_b every cycle; then both requests high -> the requester other than last_win is granted first.
REQ-040 Pulse clr in RUN, with a read by A granted one cycle earlier -> rvalid_a still delivered; 8-cycle INIT sweep follows; afterwards a read of any address returns INIT_VAL.
REQ-041 Drop rst at INIT cycle 4 and release it -> outputs 0 immediately; the sweep restarts at address 0 and completes 8 writes.

Source files
------------

// File: rtl/sp_sram_arb.sv
// Two-requester round-robin arbiter in front of a single-port SRAM.
// After reset and on clr it sweeps INIT_VAL into all 8 words, then arbitrates.
//
// Ports:
//   clk, rst (async, active-low)
//   req/we/addr/wdata _a/_b : requester access inputs
//   clr                     : re-run the init sweep (ignored during the sweep)
//   gnt_a/gnt_b             : combinational grant, access lands at next posedge
//   rvalid_a/rvalid_b       : rdata valid for that requester (1-cycle latency)
//   rdata                   : SRAM read data passthrough
//   init_done               : sweep finished, arbiter running
//   mem_addr/mem_din/mem_wr_en/mem_dout : SRAM port
module sp_sram_arb #(
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [2:0] addr_a,
  input  logic [2:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  input  logic       clr,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic [7:0] rdata,
  output logic       init_done,
  output logic [2:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_wr_en,
  input  logic [7:0] mem_dout
);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_b_q;
  logic [2:0] addr_q;
  logic [7:0] din_q;
  logic       ga, gb, wr;
  logic [2:0] addr;
  logic [7:0] din;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ga      = 1'b0;
    gb      = 1'b0;
    wr      = 1'b0;
    addr    = addr_q;
    din     = din_q;
    unique case (state_q)
      INIT: begin
        wr    = 1'b1;
        addr  = cnt_q;
        din   = INIT_VAL;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7)
          state_d = RUN;
      end
      RUN: begin
        if (clr) begin
          state_d = INIT;
          cnt_d   = 3'd0;
        end else begin
          // on conflict, A wins only if B won last time
          ga = req_a & (~req_b | last_b_q);
          gb = req_b & ~ga;
          unique case (1'b1)
            ga: begin
              wr   = we_a;
              addr = addr_a;
              din  = wdata_a;
            end
            gb: begin
              wr   = we_b;
              addr = addr_b;
              din  = wdata_b;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // reset state is INIT, which would otherwise drive a write
  assign gnt_a     = rst & ga;
  assign gnt_b     = rst & gb;
  assign mem_wr_en = rst & wr;
  assign mem_addr  = rst ? addr : 3'd0;
  assign mem_din   = rst ? din : 8'd0;
  assign init_done = (state_q == RUN);
  assign rdata     = mem_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      cnt_q    <= 3'd0;
      last_b_q <= 1'b1;
      addr_q   <= 3'd0;
      din_q    <= 8'd0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr;
      din_q    <= din;
      rvalid_a <= ga & ~we_a;
      rvalid_b <= gb & ~we_b;
      if (ga | gb)
        last_b_q <= gb;
    end
  end

endmodule

// File: tb/tb_sp_sram_arb.sv
// Testbench for sp_sram_arb: SRAM model, reference model compare
// process, and directed scenarios with literal expectations.
module tb_sp_sram_arb;

  localparam logic [7:0] IV = 8'h3C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 0, req_b = 0, we_a = 0, we_b = 0, clr = 0;
  logic [2:0] addr_a = 0, addr_b = 0;
  logic [7:0] wdata_a = 0, wdata_b = 0;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
  logic [7:0] rdata, mem_din, mem_dout;
  logic [2:0] mem_addr;
  logic       mem_wr_en;

  int total = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sp_sram_arb #(.INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b),
    .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .clr(clr),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .init_done(init_done),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wr_en(mem_wr_en), .mem_dout(mem_dout)
  );

  logic [7:0] sram [8];
  always_ff @(posedge clk) begin
    if (mem_wr_en) sram[mem_addr] <= mem_din;
    else mem_dout <= sram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit       m_run;
  int       m_swept;
  bit       m_pref_a;
  int       m_pend;
  logic [7:0] m_pdata;
  int       m_haddr;
  logic [7:0] m_hdin;
  logic [7:0] m_mem [8];

  initial begin
    int w, e_wr, e_addr;
    logic [7:0] e_din;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_outs",
            {gnt_a, gnt_b, rvalid_a, rvalid_b, init_done, mem_wr_en,
             mem_addr, mem_din}, 0);
        m_run = 0; m_swept = 0; m_pref_a = 1; m_pend = 0;
        m_haddr = 0; m_hdin = 0;
      end else begin
        w = 0;
        if (!m_run) begin
          e_wr = 1; e_addr = m_swept; e_din = IV;
        end else begin
          e_wr = 0; e_addr = m_haddr; e_din = m_hdin;
          if (!clr) begin
            if (req_a && req_b) w = m_pref_a ? 1 : 2;
            else if (req_a) w = 1;
            else if (req_b) w = 2;
          end
          if (w == 1) begin
            e_wr = int'(we_a); e_addr = int'(addr_a); e_din = wdata_a;
          end else if (w == 2) begin
            e_wr = int'(we_b); e_addr = int'(addr_b); e_din = wdata_b;
          end
        end
        chk("m_gnt", {gnt_a, gnt_b}, {30'd0, w == 1, w == 2});
        chk("m_wr", mem_wr_en, e_wr);
        chk("m_addr", mem_addr, e_addr);
        chk("m_din", mem_din, e_din);
        chk("m_done", init_done, m_run);
        chk("m_rvalid", {rvalid_a, rvalid_b},
            {30'd0, m_pend == 1, m_pend == 2});
        if (m_pend != 0) chk("m_rdata", rdata, m_pdata);
        // effect of the coming posedge
        m_pend = 0;
        if (!m_run) begin
          m_mem[e_addr] = IV;
          m_swept++;
          if (m_swept == 8) m_run = 1;
        end else if (clr) begin
          m_run = 0; m_swept = 0;
        end else if (w != 0) begin
          m_pref_a = (w == 2);
          if (e_wr != 0) m_mem[e_addr] = e_din;
          else begin
            m_pend = w; m_pdata = m_mem[e_addr];
          end
        end
        m_haddr = e_addr; m_hdin = e_din;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input bit r, input bit ra, input bit wa,
                      input logic [2:0] aa, input logic [7:0] da,
                      input bit rb, input bit wb,
                      input logic [2:0] ab, input logic [7:0] db,
                      input bit c);
    @(posedge clk);
    #1;
    rst = r; req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; clr = c;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sweep(input string nm, input int n, input int clr_at);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, i == clr_at);
      chk({nm, "_wr"}, mem_wr_en, 1);
      chk({nm, "_addr"}, mem_addr, i);
      chk({nm, "_din"}, mem_din, IV);
      chk({nm, "_nognt"}, {gnt_a, gnt_b}, 0);
    end
  endtask

  task automatic hit_reset(input string nm);
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk({nm, "_zero"},
        {gnt_a, gnt_b, rvalid_a, rvalid_b, init_done, mem_wr_en,
         mem_addr, mem_din}, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_wr", mem_wr_en, 0);
    chk("rst_done", init_done, 0);

    sweep("init", 8, -1);
    idle();
    chk("done_cyc9", init_done, 1);
    chk("idle_wr", mem_wr_en, 0);

    step(1, 1, 1, 3, 8'hA5, 0, 0, 0, 0, 0);
    chk("wr_gnt_a", gnt_a, 1);
    step(1, 1, 0, 3, 8'h00, 0, 0, 0, 0, 0);
    chk("rd_gnt_a", gnt_a, 1);
    chk("wr_no_rvalid", rvalid_a, 0);
    idle();
    chk("rv_a", {rvalid_a, rvalid_b}, 2'b10);
    chk("rd_a5", rdata, 8'hA5);

    step(1, 1, 1, 1, 8'h11, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 2, 8'h22, 0);
    chk("wr_gnt_b", gnt_b, 1);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 1, 0, 1, 0, 2, 0, 0);
      chk("rr_gnt", {gnt_a, gnt_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("rr_rv", {rvalid_a, rvalid_b}, (k % 2 == 1) ? 2'b10 : 2'b01);
        chk("rr_data", rdata, (k % 2 == 1) ? 8'h11 : 8'h22);
      end
    end
    idle();
    chk("rr_rv_last", {rvalid_a, rvalid_b}, 2'b01);
    chk("rr_data_last", rdata, 8'h22);

    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 1, 0, 2, 0, 0);
      chk("only_b", {gnt_a, gnt_b}, 2'b01);
    end
    step(1, 1, 0, 1, 0, 1, 0, 2, 0, 0);
    chk("conf_after_b", {gnt_a, gnt_b}, 2'b10);

    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    chk("pre_clr_gnt", gnt_a, 1);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 1);
    chk("clr_nognt", {gnt_a, gnt_b}, 0);
    chk("clr_rv", rvalid_a, 1);
    chk("clr_rdata", rdata, 8'hA5);
    sweep("clr_sweep", 8, 3);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    chk("post_clr_rv_a", rvalid_a, 1);
    chk("post_clr_rd3", rdata, IV);
    idle();
    chk("post_clr_rv_b", rvalid_b, 1);
    chk("post_clr_rd1", rdata, IV);

    step(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    hit_reset("rst_inflight");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sweep("resweep", 4, -1);
    hit_reset("rst_mid");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sweep("final_sweep", 8, -1);
    idle();
    chk("final_done", init_done, 1);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    idle();
    chk("final_rd", rdata, IV);
    idle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
